program_memory_with_fsm: RTL and testbench
==========================================

# program_memory_with_fsm

Behavioural model of the 16K-word (32 KB) ATmega328PB flash program memory, with a built-in parallel-programming FSM. The CPU side fetches 16-bit instruction words by program counter. The programming side follows the parallel-programming protocol: load command, address and data, then erase and program a page, or read bytes back. It sits between the core's fetch stage and the programming interface, and is used for simulation only.

## Interface
- T_ERASE, 64000, erase duration in clk cycles (3.2 ms at 20 MHz).
- T_PROG, 64000, program duration in clk cycles.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PC  in  14  word address for instruction fetch.
- PC_RD  in  1  fetch strobe.
- Dout  out  16  fetched instruction word (registered).
- XTAL1  in  1  programming-action enable, level-sensitive per clk edge.
- XA  in  2  action select: 00 load address, 01 load data, 10 load command, 11 none.
- BS1  in  1  byte select: 0 low byte, 1 high byte.
- DATA  in  8  programming data, address or command byte.
- WR  in  1  active-low write strobe; the falling edge starts an operation.
- OE  in  1  active-low output enable for flash read.
- DATA_OUT  out  8  byte read back in read-flash mode.
- RDY  out  1  1 = idle; 0 = erase or program in progress.
- Erase  out  1  erase phase active.
- Prog  out  1  program phase active.

## Operation
- Storage is `memory[256 rows][128 bytes]`. It powers up at 0xFF, is non-volatile (rst does not clear it), and the bench may preload it hierarchically.
- Word address A[13:0] = {ADRH[5:0], ADRL}.
- Row = A[13:6]. Word in page = A[5:0]. Low byte index = 2·A[5:0]; high byte index = 2·A[5:0]+1.
- Rows 0–223 form the RWW section; rows 224–255 form the NRWW section.
- Programming actions run on a clk edge only when XTAL1=1, RDY=1 and no WR falling edge is sampled on that edge. A WR falling edge takes precedence over any XA action on the same edge.
  - XA=10: CMD ← DATA. Recognised commands: 0x10 write flash, 0x02 read flash, 0x80 chip erase. Any other value means no operation.
  - XA=00: BS1=0 sets ADRL ← DATA; BS1=1 sets ADRH ← DATA.
  - XA=01 with BS1=0: DLO ← DATA.
  - XA=01 with BS1=1: page buffer word A[5:0] ← {DATA, DLO}.
- WR falling edge (WR=0 now, previous sample 1), with RDY=1:
  - CMD=0x10: page erase/program of row A[13:6].
  - CMD=0x80: chip erase.
  - Otherwise: ignored.
- FSM states: IDLE, ERASE, PROG.
  - IDLE→ERASE on an accepted WR. Sets RDY=0, Erase=1, and the latched target row.
  - ERASE→PROG after T_ERASE cycles. The target row becomes 0xFF; Erase=0, Prog=1. For a chip erase, the whole array becomes 0xFF and the FSM goes to IDLE instead.
  - PROG→IDLE after T_PROG cycles. The target row is loaded from the page buffer, the buffer resets to all 0xFF, Prog=0 and RDY=1.
- Read flash: when CMD=0x02, OE=0 and RDY=1, DATA_OUT ← memory byte at A, high byte if BS1=1.
- Fetch: on an edge with PC_RD=1, Dout ← {memory[PC[13:6]][2·PC[5:0]+1], memory[PC[13:6]][2·PC[5:0]]}.
- Fetch during a busy operation: if RDY=0 and PC's row is in the same section (RWW/NRWW) as the target row, Dout ← 0xFFFF. The same rule applies to every fetch during a chip erase.
- Fetches from the other section proceed normally (read-while-write).

## Timing
- Reset values:
  - Registers: CMD=0x00, ADRL=ADRH=0, DLO=0xFF, page buffer all 0xFF, previous-WR sample=1.
  - FSM: IDLE.
  - Outputs: RDY=1, Erase=0, Prog=0, Dout=0, DATA_OUT=0.
- Reset mid-operation aborts the operation; memory keeps whatever it held on that edge.
- Load actions take effect on the same edge.
- Fetch latency is one edge: Dout is valid after the edge where PC_RD=1. Without PC_RD, Dout holds its value.
- WR is sampled on edge N. RDY falls and Erase rises on edge N.
- Erase ends at edge N+T_ERASE. RDY returns at edge N+T_ERASE+T_PROG, and the row data is valid from that edge.
- A WR held low triggers only once. WR and XA actions while RDY=0 are ignored.

## Test plan
- Preload memory[1][2]=0x9F and memory[1][3]=0xF6; PC=0x041, PC_RD=1 for 1 cycle → Dout=0xF69F.
- Page program with T_ERASE=T_PROG=4:
  - Stimulus: CMD 0x10, ADRL 0x82, data 0x78 then 0x96 (BS1=1), ADRL 0x84, data 0x42 then 0x97, ADRH 0x70, WR pulse.
  - RDY=0 for 8 cycles.
  - Row 0xC2: bytes 4/5 = 0x78/0x96, bytes 8/9 = 0x97 high over 0x42 low, all other bytes 0xFF.
- Read-while-write: during that RWW program, fetch PC=0x3841 (NRWW row 225, preloaded 0x99/0x66) → Dout=0x6699. Fetch PC=0x041 → Dout=0xFFFF.
- Read flash: CMD 0x02, A=0x041, BS1=1, OE=0 → DATA_OUT=0xF6. With BS1=0 → DATA_OUT=0x9F.
- Chip erase: CMD 0x80, WR pulse → after T_ERASE, RDY=1 and every byte reads 0xFF. Prog never asserts.
- Reset/precedence:
  - rst mid-ERASE → RDY=1 and Erase=0 the next edge.
  - WR falling on the same edge as XA=00 with DATA=0xFF → ADRH is unchanged.

Source files
------------

// File: rtl/program_memory_with_fsm_if.sv
// Fetch and parallel-programming bus of the ATmega328PB flash model.
// The memory is the slave; the core/programmer side is the master.
interface program_memory_with_fsm_if;
    logic [13:0] PC;
    logic        PC_RD;
    logic [15:0] Dout;
    logic        XTAL1;
    logic [1:0]  XA;
    logic        BS1;
    logic [7:0]  DATA;
    logic        WR;
    logic        OE;
    logic [7:0]  DATA_OUT;
    logic        RDY;
    logic        Erase;
    logic        Prog;

    modport master (
        output PC, PC_RD, XTAL1, XA, BS1, DATA, WR, OE,
        input  Dout, DATA_OUT, RDY, Erase, Prog
    );

    modport slave (
        input  PC, PC_RD, XTAL1, XA, BS1, DATA, WR, OE,
        output Dout, DATA_OUT, RDY, Erase, Prog
    );
endinterface

// File: rtl/program_memory_with_fsm.sv
// 16K-word flash program memory with instruction fetch port and a
// parallel-programming FSM (page erase/program, chip erase, byte read-back).
module program_memory_with_fsm #(
    parameter int unsigned T_ERASE = 64000,
    parameter int unsigned T_PROG  = 64000
) (
    input  logic                      clk,
    input  logic                      rst,
    program_memory_with_fsm_if.slave  bus
);

    localparam int unsigned T_MAX = (T_ERASE > T_PROG) ? T_ERASE : T_PROG;
    localparam int          CNT_W = $clog2(T_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ERASE = 2'd1;
    localparam logic [1:0] ST_PROG  = 2'd2;

    localparam logic [7:0] CMD_WRITE_FLASH = 8'h10;
    localparam logic [7:0] CMD_READ_FLASH  = 8'h02;
    localparam logic [7:0] CMD_CHIP_ERASE  = 8'h80;

    localparam logic [1:0] XA_LOAD_ADDR = 2'b00;
    localparam logic [1:0] XA_LOAD_DATA = 2'b01;
    localparam logic [1:0] XA_LOAD_CMD  = 2'b10;
    localparam logic [1:0] XA_NONE      = 2'b11;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cmd;
    logic [7:0]       adrl;
    logic [5:0]       adrh;
    logic [7:0]       dlo;
    logic             wr_prev;
    logic [7:0]       target_row;
    logic             chip_op;
    logic [15:0]      dout;
    logic [7:0]       data_out;
    logic [127:0][7:0] page_buf;
    logic [127:0][7:0] memory [256];

    logic [13:0] addr;
    logic        rdy;
    logic        wr_fall;
    logic        op_start;
    logic        act_en;
    logic        erase_done;
    logic        prog_done;
    logic        fetch_blocked;

    assign addr       = {adrh, adrl};
    assign rdy        = (state == ST_IDLE);
    assign wr_fall    = !bus.WR && wr_prev;
    assign op_start   = rdy && wr_fall &&
                        ((cmd == CMD_WRITE_FLASH) || (cmd == CMD_CHIP_ERASE));
    // A WR falling edge wins over any load action sampled on the same edge.
    assign act_en     = bus.XTAL1 && rdy && !wr_fall;
    assign erase_done = (state == ST_ERASE) && (cnt == '0);
    assign prog_done  = (state == ST_PROG) && (cnt == '0);

    // Rows 224..255 (top three row bits set) are the NRWW section.
    assign fetch_blocked = !rdy &&
                           (chip_op || ((&bus.PC[13:11]) == (&target_row[7:5])));

    assign bus.RDY      = rdy;
    assign bus.Erase    = (state == ST_ERASE);
    assign bus.Prog     = (state == ST_PROG);
    assign bus.Dout     = dout;
    assign bus.DATA_OUT = data_out;

    // NOTE: the flash array is non-volatile, so it has no reset branch; a reset
    // only suppresses the write that would otherwise land on that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (erase_done && chip_op) begin
                for (int unsigned r = 0; r < 256; r++) begin
                    memory[8'(r)] <= '1;
                end
            end else if (erase_done) begin
                memory[target_row] <= '1;
            end else if (prog_done) begin
                memory[target_row] <= page_buf;
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every read in this
    // block sees the pre-edge value, matching the registered protocol timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cmd        <= 8'h00;
            adrl       <= 8'h00;
            adrh       <= 6'h00;
            dlo        <= 8'hFF;
            page_buf   <= '1;
            wr_prev    <= 1'b1;
            target_row <= 8'h00;
            chip_op    <= 1'b0;
            dout       <= 16'h0000;
            data_out   <= 8'h00;
        end else begin
            wr_prev <= bus.WR;

            case (state)
                ST_IDLE: begin
                    if (op_start) begin
                        state      <= ST_ERASE;
                        cnt        <= CNT_W'(T_ERASE - 1);
                        target_row <= addr[13:6];
                        chip_op    <= (cmd == CMD_CHIP_ERASE);
                    end
                end
                ST_ERASE: begin
                    if (cnt == '0) begin
                        if (chip_op) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_PROG;
                            cnt   <= CNT_W'(T_PROG - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PROG: begin
                    if (cnt == '0) begin
                        state    <= ST_IDLE;
                        page_buf <= '1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (act_en) begin
                case (bus.XA)
                    XA_LOAD_CMD: cmd <= bus.DATA;
                    XA_LOAD_ADDR: begin
                        if (bus.BS1) adrh <= bus.DATA[5:0];
                        else         adrl <= bus.DATA;
                    end
                    XA_LOAD_DATA: begin
                        if (bus.BS1) begin
                            page_buf[{addr[5:0], 1'b0}] <= dlo;
                            page_buf[{addr[5:0], 1'b1}] <= bus.DATA;
                        end else begin
                            dlo <= bus.DATA;
                        end
                    end
                    XA_NONE: ;
                    default: ;
                endcase
            end

            if ((cmd == CMD_READ_FLASH) && !bus.OE && rdy) begin
                data_out <= memory[addr[13:6]][{addr[5:0], bus.BS1}];
            end

            if (bus.PC_RD) begin
                if (fetch_blocked) begin
                    dout <= 16'hFFFF;
                end else begin
                    dout <= {memory[bus.PC[13:6]][{bus.PC[5:0], 1'b1}],
                             memory[bus.PC[13:6]][{bus.PC[5:0], 1'b0}]};
                end
            end
        end
    end

endmodule

// File: tb/tb_program_memory_with_fsm.sv
// Scoreboard bench for program_memory_with_fsm: directed programming sequences,
// expected fetch/read-back bytes queued at issue and compared by a monitor.
module tb_program_memory_with_fsm;

    localparam int unsigned T_E = 4;
    localparam int unsigned T_P = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    program_memory_with_fsm_if bus ();

    program_memory_with_fsm #(
        .T_ERASE (T_E),
        .T_PROG  (T_P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] dout_q [$];
    logic [7:0]  rd_q   [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // Monitor: a fetch or an enabled flash read on a posedge presents data
    // that is compared against the queue head on the following negedge.
    logic fetch_pend = 1'b0;
    logic read_pend  = 1'b0;

    always @(posedge clk) begin
        fetch_pend <= !rst && bus.PC_RD;
        read_pend  <= !rst && !bus.OE && bus.RDY;
    end

    always @(negedge clk) begin
        if (fetch_pend) begin
            if (dout_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dout_unexpected: got %h with nothing queued", bus.Dout);
            end else begin
                check("dout", bus.Dout, dout_q.pop_front());
            end
        end
        if (read_pend) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL data_out_unexpected: got %h with nothing queued", bus.DATA_OUT);
            end else begin
                check("data_out", {8'h00, bus.DATA_OUT}, {8'h00, rd_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cmd(input logic [7:0] c);
        bus.XA = 2'b10; bus.DATA = c;
        tick();
        bus.XA = 2'b11;
    endtask

    task automatic load_adr(input logic hi, input logic [7:0] v);
        bus.XA = 2'b00; bus.BS1 = hi; bus.DATA = v;
        tick();
        bus.XA = 2'b11;
    endtask

    task automatic load_data(input logic hi, input logic [7:0] v);
        bus.XA = 2'b01; bus.BS1 = hi; bus.DATA = v;
        tick();
        bus.XA = 2'b11;
    endtask

    task automatic wr_pulse();
        bus.WR = 1'b0;
        tick();
        bus.WR = 1'b1;
    endtask

    task automatic fetch(input logic [13:0] pc, input logic [15:0] exp);
        bus.PC = pc; bus.PC_RD = 1'b1;
        dout_q.push_back(exp);
        tick();
        bus.PC_RD = 1'b0;
    endtask

    task automatic read_byte(input logic hi, input logic [7:0] exp);
        bus.OE = 1'b0; bus.BS1 = hi;
        rd_q.push_back(exp);
        tick();
        bus.OE = 1'b1;
    endtask

    initial begin
        int  busy;
        bit  done;
        bit  prog_seen;

        bus.PC = '0; bus.PC_RD = 1'b0; bus.XTAL1 = 1'b1; bus.XA = 2'b11;
        bus.BS1 = 1'b0; bus.DATA = '0; bus.WR = 1'b1; bus.OE = 1'b1;

        for (int r = 0; r < 256; r++) dut.memory[r] = '1;
        dut.memory[1][2]   = 8'h9F;
        dut.memory[1][3]   = 8'hF6;
        dut.memory[225][2] = 8'h99;
        dut.memory[225][3] = 8'h66;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_rdy",      {15'd0, bus.RDY},   16'h0001);
        check("reset_erase",    {15'd0, bus.Erase}, 16'h0000);
        check("reset_prog",     {15'd0, bus.Prog},  16'h0000);
        check("reset_dout",     bus.Dout,           16'h0000);
        check("reset_data_out", {8'h00, bus.DATA_OUT}, 16'h0000);

        // Plain fetch of preloaded word 0x041.
        fetch(14'h0041, 16'hF69F);

        // Page program of row 0xC2 with read-while-write fetches.
        load_cmd(8'h10);
        load_adr(1'b0, 8'h82);
        load_data(1'b0, 8'h78);
        load_data(1'b1, 8'h96);
        load_adr(1'b0, 8'h84);
        load_data(1'b0, 8'h42);
        load_data(1'b1, 8'h97);
        load_adr(1'b1, 8'h70);
        wr_pulse();
        check("prog_start_rdy",   {15'd0, bus.RDY},   16'h0000);
        check("prog_start_erase", {15'd0, bus.Erase}, 16'h0001);

        busy = 0; done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (k == 1) begin
                bus.PC = 14'h3841; bus.PC_RD = 1'b1; dout_q.push_back(16'h6699);
            end else if (k == 2) begin
                bus.PC = 14'h0041; dout_q.push_back(16'hFFFF);
            end else begin
                bus.PC_RD = 1'b0;
            end
            tick();
            if (k == 4) begin
                check("phase_erase_off", {15'd0, bus.Erase}, 16'h0000);
                check("phase_prog_on",   {15'd0, bus.Prog},  16'h0001);
            end
            if (bus.RDY) begin
                done = 1'b1;
                busy = k;
            end
        end
        bus.PC_RD = 1'b0;
        check("prog_busy_cycles", 16'(busy), 16'd8);
        check("prog_end_prog",    {15'd0, bus.Prog}, 16'h0000);

        fetch(14'h3082, 16'h9678);
        fetch(14'h3084, 16'h9742);
        fetch(14'h3080, 16'hFFFF);
        fetch(14'h30BF, 16'hFFFF);

        // Read flash back byte by byte.
        load_cmd(8'h02);
        load_adr(1'b0, 8'h41);
        load_adr(1'b1, 8'h00);
        read_byte(1'b1, 8'hF6);
        read_byte(1'b0, 8'h9F);

        // Chip erase: no program phase, every fetch blocked while busy.
        load_cmd(8'h80);
        wr_pulse();
        check("chip_start_erase", {15'd0, bus.Erase}, 16'h0001);
        busy = 0; done = 1'b0; prog_seen = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (k == 1) begin
                bus.PC = 14'h3841; bus.PC_RD = 1'b1; dout_q.push_back(16'hFFFF);
            end else begin
                bus.PC_RD = 1'b0;
            end
            tick();
            prog_seen = prog_seen | bus.Prog;
            if (bus.RDY) begin
                done = 1'b1;
                busy = k;
            end
        end
        bus.PC_RD = 1'b0;
        check("chip_busy_cycles", 16'(busy), 16'd4);
        check("chip_prog_seen",   {15'd0, prog_seen}, 16'h0000);
        fetch(14'h0041, 16'hFFFF);
        fetch(14'h3082, 16'hFFFF);
        fetch(14'h3841, 16'hFFFF);
        fetch(14'h3FFF, 16'hFFFF);

        // Reset in the middle of an erase aborts it.
        load_cmd(8'h10);
        wr_pulse();
        check("abort_erase_on", {15'd0, bus.Erase}, 16'h0001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rdy",   {15'd0, bus.RDY},   16'h0001);
        check("abort_erase", {15'd0, bus.Erase}, 16'h0000);

        // WR fall and an ADRH load on the same edge: the load is dropped.
        dut.memory[1][3] = 8'h5A;
        load_cmd(8'h02);
        load_adr(1'b0, 8'h41);
        bus.XA = 2'b00; bus.BS1 = 1'b1; bus.DATA = 8'hFF; bus.WR = 1'b0;
        tick();
        bus.WR = 1'b1; bus.XA = 2'b11;
        check("precedence_rdy", {15'd0, bus.RDY}, 16'h0001);
        read_byte(1'b1, 8'h5A);

        tick(); tick(); tick();
        check("dout_queue_drained", 16'(dout_q.size()), 16'd0);
        check("read_queue_drained", 16'(rd_q.size()),   16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
